uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 74 +++++++
 tb/tb_uart_rx_fifo.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive FIFO storing data plus error tag, with registered pop output, status flags and sticky overflow
module uart_rx_fifo #(
  parameter int DATA_BITS   = 8,
  parameter int FIFO_WIDTH  = 4,
  parameter int FULL_THRESH = 2 ** (FIFO_WIDTH - 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_BITS-1:0]  Rx_Data,
  input  logic                  Rx_Err,
  input  logic                  Data_Rdy,
  input  logic                  Pop_Data,
  input  logic                  BIST_Mode,
  input  logic                  Clr_Ovf,
  output logic [DATA_BITS-1:0]  Data_Out,
  output logic                  Err_Out,
  output logic                  Data_Valid,
  output logic                  FIFO_Empty,
  output logic                  FIFO_Full,
  output logic                  FIFO_Overflow,
  output logic [FIFO_WIDTH:0]   FIFO_Count
);
  localparam int DEPTH_I = 2 ** FIFO_WIDTH;
  localparam logic [FIFO_WIDTH:0] DEPTH = (FIFO_WIDTH + 1)'(DEPTH_I);
  localparam logic [FIFO_WIDTH:0] THRESH = (FIFO_WIDTH + 1)'(FULL_THRESH);
  logic [DATA_BITS:0] mem [DEPTH_I];
  logic [FIFO_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_WIDTH:0] count_q, count_d;
  logic [DATA_BITS-1:0] dout_q, dout_d;
  logic err_q, err_d, dv_q, dv_d, ovf_q, ovf_d;
  logic push_req, pop_req, do_push, do_pop;
  always_comb begin
    push_req = Data_Rdy & ~BIST_Mode;
    pop_req  = Pop_Data & ~BIST_Mode;
    do_pop   = pop_req && count_q != '0;
    do_push  = push_req && (count_q != DEPTH || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + FIFO_WIDTH'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + FIFO_WIDTH'(1) : rd_ptr_q;
    count_d  = count_q + (FIFO_WIDTH + 1)'(do_push) - (FIFO_WIDTH + 1)'(do_pop);
    dout_d   = do_pop ? mem[rd_ptr_q][DATA_BITS-1:0] : dout_q;
    err_d    = do_pop ? mem[rd_ptr_q][DATA_BITS] : err_q;
    dv_d     = do_pop;
    ovf_d    = (push_req && !do_push) ? 1'b1 : Clr_Ovf ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      err_q    <= 1'b0;
      dv_q     <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      err_q    <= err_d;
      dv_q     <= dv_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr_q] <= {Rx_Err, Rx_Data};
  end
  assign Data_Out      = dout_q;
  assign Err_Out       = err_q;
  assign Data_Valid    = dv_q;
  assign FIFO_Count    = count_q;
  assign FIFO_Empty    = count_q == '0;
  assign FIFO_Full     = count_q >= THRESH;
  assign FIFO_Overflow = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst, rx_err, data_rdy, pop_data, bist_mode, clr_ovf;
  logic [7:0] rx_data, data_out;
  logic err_out, data_valid, fifo_empty, fifo_full, fifo_overflow;
  logic [4:0] fifo_count;
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  uart_rx_fifo #(.DATA_BITS(8), .FIFO_WIDTH(4), .FULL_THRESH(8)) dut (
    .clk(clk), .rst(rst), .Rx_Data(rx_data), .Rx_Err(rx_err), .Data_Rdy(data_rdy),
    .Pop_Data(pop_data), .BIST_Mode(bist_mode), .Clr_Ovf(clr_ovf), .Data_Out(data_out),
    .Err_Out(err_out), .Data_Valid(data_valid), .FIFO_Empty(fifo_empty), .FIFO_Full(fifo_full),
    .FIFO_Overflow(fifo_overflow), .FIFO_Count(fifo_count)
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic op(input logic push, input logic pop, input logic [7:0] d, input logic e);
    data_rdy = push;
    pop_data = pop;
    rx_data = d;
    rx_err = e;
    tick();
    data_rdy = 1'b0;
    pop_data = 1'b0;
    rx_err = 1'b0;
  endtask
  task automatic pop_chk(input string tag, input logic [7:0] exp);
    op(1'b0, 1'b1, 8'h00, 1'b0);
    chk({tag, "_dv"}, data_valid, 1);
    chk({tag, "_data"}, data_out, exp);
  endtask
  initial begin
    rst = 1'b1; rx_data = '0; rx_err = 1'b0; data_rdy = 1'b0; pop_data = 1'b0;
    bist_mode = 1'b0; clr_ovf = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_count", fifo_count, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    chk("rst_ovf", fifo_overflow, 0);
    chk("rst_dv", data_valid, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_err", err_out, 0);
    op(1'b1, 1'b0, 8'h11, 1'b0);
    chk("t1_count1", fifo_count, 1);
    chk("t1_empty1", fifo_empty, 0);
    op(1'b1, 1'b0, 8'h22, 1'b0);
    op(1'b1, 1'b0, 8'h33, 1'b0);
    chk("t1_count3", fifo_count, 3);
    pop_chk("t1_pop0", 8'h11);
    pop_chk("t1_pop1", 8'h22);
    pop_chk("t1_pop2", 8'h33);
    chk("t1_empty", fifo_empty, 1);
    chk("t1_count0", fifo_count, 0);
    op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t1_under_dv", data_valid, 0);
    chk("t1_under_hold", data_out, 8'h33);
    chk("t1_under_count", fifo_count, 0);
    for (int i = 0; i < 17; i++) begin
      op(1'b1, 1'b0, 8'(i), 1'b0);
      if (i == 6) chk("t2_full_at7", fifo_full, 0);
      if (i == 7) chk("t2_full_at8", fifo_full, 1);
      if (i == 15) chk("t2_ovf_at16", fifo_overflow, 0);
    end
    chk("t2_count16", fifo_count, 16);
    chk("t2_ovf", fifo_overflow, 1);
    for (int i = 0; i < 16; i++) pop_chk($sformatf("t2_pop%0d", i), 8'(i));
    chk("t2_drain_count", fifo_count, 0);
    chk("t2_ovf_sticky", fifo_overflow, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t2_clr_ovf", fifo_overflow, 0);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 12; i++) op(1'b1, 1'b0, 8'(8'h40 * (r + 1) + i), 1'b0);
      chk($sformatf("t3_count12_%0d", r), fifo_count, 12);
      for (int i = 0; i < 12; i++) pop_chk($sformatf("t3_r%0d_pop%0d", r, i), 8'(8'h40 * (r + 1) + i));
    end
    chk("t3_count0", fifo_count, 0);
    op(1'b1, 1'b1, 8'h55, 1'b0);
    chk("t4_sim0_count", fifo_count, 1);
    chk("t4_sim0_dv", data_valid, 0);
    pop_chk("t4_pop55", 8'h55);
    for (int i = 0; i < 5; i++) op(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
    op(1'b1, 1'b1, 8'h65, 1'b0);
    chk("t4_sim5_count", fifo_count, 5);
    chk("t4_sim5_dv", data_valid, 1);
    chk("t4_sim5_data", data_out, 8'h60);
    for (int i = 0; i < 11; i++) op(1'b1, 1'b0, 8'(8'h66 + i), 1'b0);
    chk("t4_fill16", fifo_count, 16);
    op(1'b1, 1'b1, 8'h71, 1'b0);
    chk("t4_sim16_count", fifo_count, 16);
    chk("t4_sim16_ovf", fifo_overflow, 0);
    chk("t4_sim16_data", data_out, 8'h61);
    clr_ovf = 1'b1;
    op(1'b1, 1'b0, 8'h72, 1'b0);
    clr_ovf = 1'b0;
    chk("t4_set_wins", fifo_overflow, 1);
    chk("t4_drop_count", fifo_count, 16);
    for (int i = 0; i < 7; i++) pop_chk($sformatf("t4_pop%0d", i), 8'(8'h62 + i));
    chk("t6_pre_count", fifo_count, 9);
    rst = 1'b1;
    op(1'b1, 1'b1, 8'hFF, 1'b1);
    rst = 1'b0;
    chk("t6_count", fifo_count, 0);
    chk("t6_empty", fifo_empty, 1);
    chk("t6_full", fifo_full, 0);
    chk("t6_ovf", fifo_overflow, 0);
    chk("t6_dout", data_out, 8'h00);
    chk("t6_dv", data_valid, 0);
    op(1'b1, 1'b0, 8'hA5, 1'b1);
    op(1'b0, 1'b1, 8'h00, 1'b0);
    chk("t5_dv", data_valid, 1);
    chk("t5_data", data_out, 8'hA5);
    chk("t5_err", err_out, 1);
    op(1'b1, 1'b0, 8'h3C, 1'b0);
    op(1'b1, 1'b0, 8'h3D, 1'b0);
    bist_mode = 1'b1;
    op(1'b1, 1'b1, 8'h77, 1'b0);
    chk("t5_bist_count", fifo_count, 2);
    chk("t5_bist_dv", data_valid, 0);
    chk("t5_bist_hold", data_out, 8'hA5);
    bist_mode = 1'b0;
    pop_chk("t5_after_bist", 8'h3C);
    chk("t5_after_err", err_out, 0);
    tick();
    chk("t5_dv_pulse", data_valid, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
